// File: rtl/if_debug_ctrl.sv
// if_debug_ctrl: instruction-fetch debug controller.
// Assembles UART RX bytes (MSB first) into 32-bit words, writes them
// sequentially into instruction memory, then gates the pipeline clock
// enable in RUN (continuous) or STEP (one cycle per 'N') mode.
// Optional feature macro: IF_DEBUG_LOAD_TIMEOUT_EN (mid-word load timeout).
module if_debug_ctrl #(
    parameter int unsigned IMEM_WORDS     = 64,
    parameter logic [31:0] HALT_WORD      = 32'hFFFF_FFFF,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    input  logic        i_halt_seen,
    output logic        o_write_en,
    output logic [31:0] o_data,
    output logic [31:0] o_addr_wr,
    output logic        o_read_en,
    output logic        o_clk_en,
    output logic        o_loaded,
    output logic        o_overflow,
    output logic        o_error,
    output logic [2:0]  o_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WRITE = 3'd2,
        RUN   = 3'd3,
        STEP  = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [31:0] LAST_ADDR = 32'(4 * (IMEM_WORDS - 1));
    localparam logic [7:0]  CH_L = 8'h4C;
    localparam logic [7:0]  CH_R = 8'h52;
    localparam logic [7:0]  CH_S = 8'h53;
    localparam logic [7:0]  CH_N = 8'h4E;
    localparam logic [7:0]  CH_Q = 8'h51;

    state_t      state_q;
    logic [31:0] word_q;
    logic [31:0] word_d;
    logic [31:0] addr_q;
    logic [1:0]  cnt_q;
    logic        loaded_q;
    logic        overflow_q;
    logic        write_en_q;
    logic [31:0] data_q;
    logic [31:0] addr_wr_q;
    logic        step_pulse_q;

`ifdef IF_DEBUG_LOAD_TIMEOUT_EN
    logic        error_q;
    logic [31:0] idle_cnt_q;
`endif

    assign word_d = {word_q[23:0], i_rx_data};

    // Controller FSM: command decode, word assembly, imem write and step pulses
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= IDLE;
            word_q       <= '0;
            addr_q       <= '0;
            cnt_q        <= '0;
            loaded_q     <= 1'b0;
            overflow_q   <= 1'b0;
            write_en_q   <= 1'b0;
            data_q       <= '0;
            addr_wr_q    <= '0;
            step_pulse_q <= 1'b0;
`ifdef IF_DEBUG_LOAD_TIMEOUT_EN
            error_q      <= 1'b0;
            idle_cnt_q   <= '0;
`endif
        end else begin
            write_en_q   <= 1'b0;
            step_pulse_q <= 1'b0;
            case (state_q)
                // DONE always has loaded_q set, so it shares IDLE's decode
                IDLE, DONE: begin
                    if (i_rx_valid) begin
                        if (i_rx_data == CH_L) begin
                            state_q    <= LOAD;
                            addr_q     <= '0;
                            cnt_q      <= '0;
                            loaded_q   <= 1'b0;
                            overflow_q <= 1'b0;
`ifdef IF_DEBUG_LOAD_TIMEOUT_EN
                            error_q    <= 1'b0;
                            idle_cnt_q <= '0;
`endif
                        end else if (i_rx_data == CH_R && loaded_q) begin
                            state_q <= RUN;
                        end else if (i_rx_data == CH_S && loaded_q) begin
                            state_q <= STEP;
                        end
                    end
                end
                LOAD: begin
                    if (i_rx_valid) begin
                        word_q <= word_d;
                        cnt_q  <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            state_q    <= WRITE;
                            write_en_q <= 1'b1;
                            data_q     <= word_d;
                            addr_wr_q  <= addr_q;
                        end
                    end
`ifdef IF_DEBUG_LOAD_TIMEOUT_EN
                    if (i_rx_valid) begin
                        idle_cnt_q <= '0;
                    end else if (cnt_q != 2'd0) begin
                        if (idle_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
                            state_q    <= IDLE;
                            cnt_q      <= '0;
                            word_q     <= '0;
                            idle_cnt_q <= '0;
                            error_q    <= 1'b1;
                        end else begin
                            idle_cnt_q <= idle_cnt_q + 32'd1;
                        end
                    end
`endif
                end
                WRITE: begin
                    if (word_q == HALT_WORD) begin
                        state_q  <= IDLE;
                        loaded_q <= 1'b1;
                    end else if (addr_q == LAST_ADDR) begin
                        state_q    <= IDLE;
                        overflow_q <= 1'b1;
                        loaded_q   <= 1'b0;
                    end else begin
                        state_q <= LOAD;
                        addr_q  <= addr_q + 32'd4;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    if (i_halt_seen) begin
                        state_q <= DONE;
                    end
                end
                STEP: begin
                    if (i_halt_seen) begin
                        state_q <= DONE;
                    end else if (i_rx_valid) begin
                        if (i_rx_data == CH_N) begin
                            step_pulse_q <= 1'b1;
                        end else if (i_rx_data == CH_Q) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef IF_DEBUG_LOAD_TIMEOUT_EN
    assign o_error = error_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign o_error        = 1'b0;
`endif

    // RUN enable drops in the same cycle halt is seen, before the state moves
    assign o_clk_en   = ((state_q == RUN) && !i_halt_seen) || step_pulse_q;
    assign o_read_en  = !((state_q == LOAD) || (state_q == WRITE));
    assign o_write_en = write_en_q;
    assign o_data     = data_q;
    assign o_addr_wr  = addr_wr_q;
    assign o_loaded   = loaded_q;
    assign o_overflow = overflow_q;
    assign o_state    = state_q;

endmodule

// File: doc/if_debug_ctrl.md
Name: if_debug_ctrl

Overview:
- Debug-unit controller for the instruction-fetch stage.
- Consumes a UART RX byte stream and assembles bytes into 32-bit words, which it writes sequentially into instruction memory through the IF write port.
- Afterwards it sequences execution by driving the IF/pipeline clock-enable in RUN (continuous) or STEP (one cycle per command) mode.
- Sits between the UART receiver and the IF stage's i_write_en / i_data / i_addr_wr / i_read_en / i_clk_en inputs.

Parameters:
- IMEM_WORDS, 64, instruction memory depth in 32-bit words; byte address space = 4*IMEM_WORDS (must be ≤ 64 for 8-bit address).
- HALT_WORD, 32'hFFFFFFFF, word value marking the end of a program image.
- TIMEOUT_CYCLES, 1000000, idle cycles allowed mid-word (used only with optional feature).

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_rx_data  in  8  received byte.
- i_rx_valid  in  1  one-cycle strobe, i_rx_data valid.
- i_halt_seen  in  1  pipeline retired HALT instruction.
- o_write_en  out  1  imem write strobe (one cycle per word).
- o_data  out  32  word to write.
- o_addr_wr  out  32  imem byte write address (word aligned).
- o_read_en  out  1  imem read enable.
- o_clk_en  out  1  pipeline clock enable.
- o_loaded  out  1  valid program image present.
- o_overflow  out  1  sticky: image exceeded IMEM_WORDS.
- o_error  out  1  sticky: load timeout (optional feature).
- o_state  out  3  current state, for debug readout.

Behaviour:
- Reset state (all synchronous):
  - State = IDLE; o_write_en=0, o_data=0, o_addr_wr=0.
  - o_read_en=1, o_clk_en=0; o_loaded, o_overflow, o_error all 0.
  - Byte counter=0.
- States and o_state encoding: IDLE=0, LOAD=1, WRITE=2, RUN=3, STEP=4, DONE=5.
- IDLE:
  - On i_rx_valid: 0x4C 'L' → LOAD, with address=0, byte counter=0, o_loaded=0, o_overflow=0.
  - 0x52 'R' → RUN, only if o_loaded=1.
  - 0x53 'S' → STEP, only if o_loaded=1.
  - Any other byte, or R/S while not loaded: ignored, stay IDLE.
- LOAD:
  - o_read_en=0.
  - Each valid byte shifts into the word MSB-first: word = {word[23:0], byte}; counter += 1.
  - On the 4th byte → WRITE next cycle.
- WRITE (exactly one cycle):
  - o_write_en=1, o_data=word, o_addr_wr=address.
  - Any i_rx_valid in this cycle is dropped. UART byte period makes this unreachable in practice; the bench checks for the drop.
  - Next state:
    - word == HALT_WORD → IDLE, o_loaded=1 (the HALT word itself is written).
    - Else, address == 4*(IMEM_WORDS-1) → IDLE, o_overflow=1, o_loaded=0.
    - Else address += 4, counter=0 → LOAD.
- RUN:
  - o_clk_en=1 every cycle until i_halt_seen=1.
  - Then o_clk_en=0 in that same cycle (combinational gate) → DONE.
  - RX bytes are ignored.
- STEP:
  - Byte 0x4E 'N' → o_clk_en=1 for exactly the next cycle.
  - Byte 0x51 'Q' → IDLE.
  - i_halt_seen → DONE. If i_halt_seen coincides with a byte, halt wins and the byte is ignored.
- DONE:
  - o_clk_en=0; o_loaded stays 1.
  - 'L' → LOAD, 'R' → RUN, 'S' → STEP. A re-run needs an external pipeline reset; this controller does not reset the PC.
- o_read_en=1 in all states except LOAD/WRITE.
- o_clk_en is 0 in all states other than RUN and STEP pulses.
- A reset mid-LOAD discards the partial word and clears o_loaded; a partially written image must be reloaded.
- Address arithmetic: 32-bit output; upper bits always 0 for IMEM_WORDS ≤ 64.

Optional Feature:
- Macro: IF_DEBUG_LOAD_TIMEOUT_EN.
- Defined:
  - In LOAD with counter ≠ 0, a counter increments each cycle without i_rx_valid.
  - On reaching TIMEOUT_CYCLES: partial word discarded, o_error=1 (sticky until next 'L' or reset), → IDLE.
  - The counter clears on every valid byte.
- Undefined: LOAD waits indefinitely; o_error tied to 0.

Test Plan:
- Reset, then 'L' + bytes 00 00 00 20 + FF FF FF FF:
  - writes 0x00000020 @0 and 0xFFFFFFFF @4, one o_write_en pulse each;
  - o_loaded=1, state IDLE.
- Loaded, send 'R'; assert i_halt_seen 10 cycles later → o_clk_en high exactly 10 cycles, then 0, state DONE.
- Loaded, send 'S', 'N', 'N', 'Q' → exactly two single-cycle o_clk_en pulses, then state IDLE.
- 'L' + 64 non-HALT words (IMEM_WORDS=64):
  - last write @252;
  - o_overflow=1, o_loaded=0, state IDLE.
- 'R' before any load → stays IDLE, o_clk_en stays 0.
- 'L' + 2 bytes, then i_reset → all outputs at reset values; a following 'L' load starts at address 0. With IF_DEBUG_LOAD_TIMEOUT_EN and TIMEOUT_CYCLES=100: 'L' + 1 byte + 100 silent cycles → o_error=1, state IDLE.
